// File: rtl/collision_life_tracker.sv
// Purpose : frame-rate collision detector for the plane against two mountains and lava; owns life count, game_over and post-hit invulnerability.
// Latency : evaluated on the clk edge where frame_tick=1; life/game_over/hit/invulnerable are visible the next cycle (restart in OVER acts on any edge).
// Backpressure: none; inputs are sampled once per frame strobe and no handshake is exchanged with neighbours.
//
// Ports:
//   clk, rst                  system clock, synchronous active-high reset
//   frame_tick                one-cycle strobe per frame; positions stable while high
//   restart                   level, honoured only in OVER
//   plane_y                   plane top edge (plane left edge fixed at PLANE_X)
//   mountainN_x/_y            mountain left/top edge; mountain extends to screen bottom
//   lava_x/_y                 lava top-left corner
//   life                      remaining lives, zero-extended to 10 bits
//   game_over                 high in OVER
//   hit                       one-cycle pulse when a life is deducted
//   invulnerable              high during post-hit cooldown
//   hit_count (optional)      saturating 8-bit hit counter, present when COLLISION_HIT_COUNT_EN is defined
module collision_life_tracker #(
    parameter int PLANE_X         = 100,
    parameter int PLANE_SIZE      = 16,
    parameter int MOUNTAIN_W      = 30,
    parameter int LAVA_SIZE       = 16,
    parameter int START_LIVES     = 3,
    parameter int COOLDOWN_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       restart,
    input  logic [9:0] plane_y,
    input  logic [9:0] mountain1_x,
    input  logic [9:0] mountain1_y,
    input  logic [9:0] mountain2_x,
    input  logic [9:0] mountain2_y,
    input  logic [9:0] lava_x,
    input  logic [9:0] lava_y,
    output logic [9:0] life,
    output logic       game_over,
    output logic       hit,
`ifdef COLLISION_HIT_COUNT_EN
    output logic       invulnerable,
    output logic [7:0] hit_count
`else
    output logic       invulnerable
`endif
);

    localparam logic [1:0] S_PLAYING  = 2'd0;
    localparam logic [1:0] S_COOLDOWN = 2'd1;
    localparam logic [1:0] S_OVER     = 2'd2;

    localparam int              CW        = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
    localparam logic [CW-1:0]   CNT_LOAD  = CW'(COOLDOWN_FRAMES - 1);
    localparam logic [2:0]      LIFE_INIT = 3'(START_LIVES);

    // All bounds are 11 bits so that an edge near 1023 plus an extent never wraps back to 0.
    logic [10:0] w_px_lo, w_px_hi, w_py_lo, w_py_hi;
    logic [10:0] w_m1_lo, w_m1_hi, w_m2_lo, w_m2_hi;
    logic [10:0] w_lx_lo, w_lx_hi, w_ly_lo, w_ly_hi;
    logic        w_m1_coll, w_m2_coll, w_lava_coll, w_coll, w_hit_now;

    logic [1:0]    r_state;
    logic [2:0]    r_life;
    logic [CW-1:0] r_cnt;
    logic          r_hit;

    assign w_px_lo = 11'(PLANE_X);
    assign w_px_hi = 11'(PLANE_X + PLANE_SIZE);
    assign w_py_lo = {1'b0, plane_y};
    assign w_py_hi = {1'b0, plane_y} + 11'(PLANE_SIZE);

    assign w_m1_lo = {1'b0, mountain1_x};
    assign w_m1_hi = {1'b0, mountain1_x} + 11'(MOUNTAIN_W);
    assign w_m2_lo = {1'b0, mountain2_x};
    assign w_m2_hi = {1'b0, mountain2_x} + 11'(MOUNTAIN_W);

    assign w_lx_lo = {1'b0, lava_x};
    assign w_lx_hi = {1'b0, lava_x} + 11'(LAVA_SIZE);
    assign w_ly_lo = {1'b0, lava_y};
    assign w_ly_hi = {1'b0, lava_y} + 11'(LAVA_SIZE);

    // Mountains reach the bottom of the screen, so only the plane's bottom edge versus the peak matters vertically.
    assign w_m1_coll = (w_m1_lo <= w_px_hi) && (w_m1_hi >= w_px_lo) &&
                       (w_py_hi >= {1'b0, mountain1_y});
    assign w_m2_coll = (w_m2_lo <= w_px_hi) && (w_m2_hi >= w_px_lo) &&
                       (w_py_hi >= {1'b0, mountain2_y});
    assign w_lava_coll = (w_lx_lo <= w_px_hi) && (w_lx_hi >= w_px_lo) &&
                         (w_ly_lo <= w_py_hi) && (w_ly_hi >= w_py_lo);

    assign w_coll    = w_m1_coll | w_m2_coll | w_lava_coll;
    assign w_hit_now = (r_state == S_PLAYING) && frame_tick && w_coll;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_PLAYING;
            r_life  <= LIFE_INIT;
            r_cnt   <= '0;
            r_hit   <= 1'b0;
        end else begin
            r_hit <= 1'b0;
            case (r_state)
                S_PLAYING: begin
                    if (w_hit_now) begin
                        r_hit <= 1'b1;
                        if (r_life == 3'd1) begin
                            r_life  <= 3'd0;
                            r_state <= S_OVER;
                        end else begin
                            r_life  <= r_life - 3'd1;
                            r_cnt   <= CNT_LOAD;
                            r_state <= S_COOLDOWN;
                        end
                    end
                end
                S_COOLDOWN: begin
                    // Counter runs N-1..0, so exactly N frames are immune.
                    if (frame_tick) begin
                        if (r_cnt == '0) begin
                            r_state <= S_PLAYING;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                S_OVER: begin
                    // Restart needs no frame_tick and pre-empts any collision this edge.
                    if (restart) begin
                        r_life  <= LIFE_INIT;
                        r_state <= S_PLAYING;
                    end
                end
                default: begin
                    r_state <= S_PLAYING;
                end
            endcase
        end
    end

`ifdef COLLISION_HIT_COUNT_EN
    logic [7:0] r_hit_count;

    always_ff @(posedge clk) begin
        if (rst || ((r_state == S_OVER) && restart)) begin
            r_hit_count <= 8'd0;
        end else if (w_hit_now && (r_hit_count != 8'hFF)) begin
            r_hit_count <= r_hit_count + 8'd1;
        end
    end

    assign hit_count = r_hit_count;
`endif

    assign life         = {7'd0, r_life};
    assign game_over    = (r_state == S_OVER);
    assign invulnerable = (r_state == S_COOLDOWN);
    assign hit          = r_hit;

endmodule

// File: tb/tb_collision_life_tracker.sv
module tb_collision_life_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       restart = 1'b0;
    logic [9:0] plane_y = 10'd200;
    logic [9:0] mountain1_x = 10'd300;
    logic [9:0] mountain1_y = 10'd400;
    logic [9:0] mountain2_x = 10'd500;
    logic [9:0] mountain2_y = 10'd400;
    logic [9:0] lava_x = 10'd700;
    logic [9:0] lava_y = 10'd0;
    logic [9:0] life;
    logic       game_over;
    logic       hit;
    logic       invulnerable;
`ifdef COLLISION_HIT_COUNT_EN
    logic [7:0] hit_count;
`endif

    int n_chk = 0;
    int n_err = 0;

    // Reference model: game rules in plain integers.
    int m_life = 3;
    int m_over = 0;
    int m_immune = 0;
    int m_hit = 0;
`ifdef COLLISION_HIT_COUNT_EN
    int m_hc = 0;
`endif

    collision_life_tracker dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .restart(restart),
        .plane_y(plane_y),
        .mountain1_x(mountain1_x), .mountain1_y(mountain1_y),
        .mountain2_x(mountain2_x), .mountain2_y(mountain2_y),
        .lava_x(lava_x), .lava_y(lava_y),
        .life(life), .game_over(game_over), .hit(hit),
`ifdef COLLISION_HIT_COUNT_EN
        .invulnerable(invulnerable), .hit_count(hit_count)
`else
        .invulnerable(invulnerable)
`endif
    );

    always #5 clk = ~clk;

    function automatic bit boxes_touch(int a0, int a1, int b0, int b1);
        return (a0 <= b1) && (b0 <= a1);
    endfunction

    function automatic bit model_coll();
        int px0, px1, py0, py1;
        bit m1, m2, lv;
        px0 = 100; px1 = 116;
        py0 = int'(plane_y); py1 = int'(plane_y) + 16;
        m1 = boxes_touch(px0, px1, int'(mountain1_x), int'(mountain1_x) + 30) && (py1 >= int'(mountain1_y));
        m2 = boxes_touch(px0, px1, int'(mountain2_x), int'(mountain2_x) + 30) && (py1 >= int'(mountain2_y));
        lv = boxes_touch(px0, px1, int'(lava_x), int'(lava_x) + 16) &&
             boxes_touch(py0, py1, int'(lava_y), int'(lava_y) + 16);
        return m1 || m2 || lv;
    endfunction

    function automatic void model_edge();
        bit c;
        c = model_coll();
        m_hit = 0;
        if (rst) begin
            m_life = 3; m_over = 0; m_immune = 0;
`ifdef COLLISION_HIT_COUNT_EN
            m_hc = 0;
`endif
        end else if (m_over != 0) begin
            if (restart) begin
                m_life = 3; m_over = 0;
`ifdef COLLISION_HIT_COUNT_EN
                m_hc = 0;
`endif
            end
        end else if (frame_tick) begin
            if (m_immune > 0) begin
                m_immune = m_immune - 1;
            end else if (c) begin
                m_hit = 1;
`ifdef COLLISION_HIT_COUNT_EN
                if (m_hc < 255) m_hc = m_hc + 1;
`endif
                m_life = m_life - 1;
                if (m_life == 0) m_over = 1;
                else m_immune = 60;
            end
        end
    endfunction

    // One clock: drive at negedge, model at posedge, leave #1 for sampling.
    task automatic step(input logic t, input logic rs, input logic rr);
        @(negedge clk);
        frame_tick = t;
        restart    = rs;
        rst        = rr;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_pos(input int py, input int m1x, input int m1y, input int m2x,
                           input int m2y, input int lx, input int ly);
        plane_y = 10'(py);
        mountain1_x = 10'(m1x); mountain1_y = 10'(m1y);
        mountain2_x = 10'(m2x); mountain2_y = 10'(m2y);
        lava_x = 10'(lx); lava_y = 10'(ly);
    endtask

    task automatic test_reset();
        set_pos(200, 300, 400, 500, 400, 700, 0);
        step(0, 0, 1);
        n_chk++; if (life !== 10'd3) begin n_err++; $display("FAIL reset_life: got %0d want 3", life); end
        n_chk++; if (game_over !== 1'b0) begin n_err++; $display("FAIL reset_game_over: got %b want 0", game_over); end
        n_chk++; if (invulnerable !== 1'b0 || hit !== 1'b0) begin n_err++; $display("FAIL reset_flags: inv=%b hit=%b want 0 0", invulnerable, hit); end
        step(1, 0, 0);
        n_chk++; if (life !== 10'd3 || hit !== 1'b0) begin n_err++; $display("FAIL no_overlap_tick: life=%0d hit=%b want 3 0", life, hit); end
    endtask

    task automatic test_lava_cooldown();
        int bad;
        step(0, 0, 1);
        set_pos(200, 300, 400, 500, 400, 110, 210);
        step(1, 0, 0);
        n_chk++; if (life !== 10'd2 || hit !== 1'b1 || invulnerable !== 1'b1) begin
            n_err++; $display("FAIL lava_hit: life=%0d hit=%b inv=%b want 2 1 1", life, hit, invulnerable); end
        step(0, 0, 0);
        n_chk++; if (hit !== 1'b0) begin n_err++; $display("FAIL hit_one_cycle: got %b want 0", hit); end
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            step(1, 0, 0);
            if (life !== 10'd2 || invulnerable !== (m_immune > 0)) bad++;
        end
        n_chk++; if (bad != 0) begin n_err++; $display("FAIL cooldown_immune: %0d bad frames want 0", bad); end
        n_chk++; if (invulnerable !== 1'b0) begin n_err++; $display("FAIL cooldown_end: inv=%b want 0", invulnerable); end
        step(1, 0, 0);
        n_chk++; if (life !== 10'd1 || hit !== 1'b1) begin n_err++; $display("FAIL tick61_hit: life=%0d hit=%b want 1 1", life, hit); end
    endtask

    task automatic test_multi_overlap();
        step(0, 0, 1);
        set_pos(200, 90, 216, 500, 400, 110, 210);
        step(1, 0, 0);
        n_chk++; if (life !== 10'd2) begin n_err++; $display("FAIL multi_overlap: life=%0d want 2", life); end
        step(0, 0, 1);
        set_pos(200, 90, 217, 500, 400, 700, 0);
        step(1, 0, 0);
        n_chk++; if (life !== 10'd3 || hit !== 1'b0) begin n_err++; $display("FAIL mountain_miss: life=%0d hit=%b want 3 0", life, hit); end
    endtask

    task automatic test_game_over_restart();
        step(0, 0, 1);
        set_pos(200, 300, 400, 90, 100, 700, 0);
        for (int h = 0; h < 3; h++) begin
            step(1, 0, 0);
            if (h < 2) for (int i = 0; i < 60; i++) step(1, 0, 0);
        end
        n_chk++; if (life !== 10'd0 || game_over !== 1'b1 || hit !== 1'b1) begin
            n_err++; $display("FAIL third_hit: life=%0d go=%b hit=%b want 0 1 1", life, game_over, hit); end
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        n_chk++; if (life !== 10'd0 || game_over !== 1'b1 || hit !== 1'b0) begin
            n_err++; $display("FAIL over_hold: life=%0d go=%b hit=%b want 0 1 0", life, game_over, hit); end
        // restart and tick together with overlap: restart wins, no deduction
        step(1, 1, 0);
        n_chk++; if (life !== 10'd3 || game_over !== 1'b0 || hit !== 1'b0) begin
            n_err++; $display("FAIL restart: life=%0d go=%b hit=%b want 3 0 0", life, game_over, hit); end
`ifdef COLLISION_HIT_COUNT_EN
        n_chk++; if (hit_count !== 8'd0) begin n_err++; $display("FAIL restart_hit_count: got %0d want 0", hit_count); end
`endif
    endtask

    task automatic test_wrap();
        step(0, 0, 1);
        set_pos(1015, 300, 400, 500, 400, 1020, 1020);
        step(1, 0, 0);
        n_chk++; if (life !== 10'd3) begin n_err++; $display("FAIL wrap_lava: life=%0d want 3", life); end
        set_pos(1010, 1010, 0, 500, 400, 700, 0);
        step(1, 0, 0);
        n_chk++; if (life !== 10'd3) begin n_err++; $display("FAIL wrap_mountain: life=%0d want 3", life); end
        // bottom edge 1026 must still reach lava at 1020
        set_pos(1010, 300, 400, 500, 400, 100, 1020);
        step(1, 0, 0);
        n_chk++; if (life !== 10'd2 || hit !== 1'b1) begin n_err++; $display("FAIL high_edge_hit: life=%0d hit=%b want 2 1", life, hit); end
    endtask

    task automatic test_rst_mid_cooldown();
        step(0, 0, 1);
        set_pos(200, 300, 400, 500, 400, 110, 210);
        step(1, 0, 0);
        for (int i = 0; i < 29; i++) step(1, 0, 0);
        n_chk++; if (invulnerable !== 1'b1 || life !== 10'd2) begin n_err++; $display("FAIL mid_cooldown: inv=%b life=%0d want 1 2", invulnerable, life); end
        step(0, 0, 1);
        n_chk++; if (life !== 10'd3 || invulnerable !== 1'b0) begin n_err++; $display("FAIL rst_cooldown: life=%0d inv=%b want 3 0", life, invulnerable); end
        step(1, 0, 0);
        n_chk++; if (life !== 10'd2 || hit !== 1'b1) begin n_err++; $display("FAIL post_rst_hit: life=%0d hit=%b want 2 1", life, hit); end
`ifdef COLLISION_HIT_COUNT_EN
        n_chk++; if (hit_count !== 8'd1) begin n_err++; $display("FAIL hit_count: got %0d want 1", hit_count); end
`endif
    endtask

    task automatic test_random();
        int bad_life, bad_go, bad_hit, bad_inv;
        bad_life = 0; bad_go = 0; bad_hit = 0; bad_inv = 0;
        step(0, 0, 1);
        for (int i = 0; i < 4000; i++) begin
            set_pos(int'($urandom_range(170, 240)),
                    int'($urandom_range(40, 220)), int'($urandom_range(190, 280)),
                    int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                    int'($urandom_range(60, 170)), int'($urandom_range(150, 270)));
            step(($urandom_range(0, 1) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 299) == 0));
            if (life !== 10'(m_life)) begin
                bad_life++;
                if (bad_life < 4) $display("FAIL rand_life: cycle %0d got %0d want %0d", i, life, m_life);
            end
            if (game_over !== (m_over != 0)) bad_go++;
            if (hit !== (m_hit != 0)) bad_hit++;
            if (invulnerable !== (m_immune > 0)) bad_inv++;
        end
        n_chk++; if (bad_life != 0) begin n_err++; $display("FAIL rand_life_total: %0d mismatched cycles want 0", bad_life); end
        n_chk++; if (bad_go != 0) begin n_err++; $display("FAIL rand_game_over: %0d mismatched cycles want 0", bad_go); end
        n_chk++; if (bad_hit != 0) begin n_err++; $display("FAIL rand_hit: %0d mismatched cycles want 0", bad_hit); end
        n_chk++; if (bad_inv != 0) begin n_err++; $display("FAIL rand_invulnerable: %0d mismatched cycles want 0", bad_inv); end
`ifdef COLLISION_HIT_COUNT_EN
        n_chk++; if (hit_count !== 8'(m_hc)) begin n_err++; $display("FAIL rand_hit_count: got %0d want %0d", hit_count, m_hc); end
`endif
    endtask

    initial begin
        test_reset();
        test_lava_cooldown();
        test_multi_overlap();
        test_game_over_restart();
        test_wrap();
        test_rst_mid_cooldown();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/collision_life_tracker.md
Name: collision_life_tracker

Overview:
- Upstream of the pixel colour stage. Consumes the per-frame positions of the plane, mountains and lava, and detects plane overlap using the same box geometry the colour stage draws.
- Owns the life count and game_over flag, with a post-hit invulnerability window.
- Evaluates once per frame on a frame_tick strobe from the VGA timing block. Outputs drive the colour stage's life and game_over inputs.

Parameters:
- PLANE_X, 100, fixed plane left edge (pixels)
- PLANE_SIZE, 16, plane box extent; box spans [x, x+16] inclusive
- MOUNTAIN_W, 30, mountain width; spans [mx, mx+30]; vertical extent from my down to the screen bottom
- LAVA_SIZE, 16, lava box extent; spans [lx, lx+16] × [ly, ly+16]
- START_LIVES, 3, lives loaded on reset/restart (1..7)
- COOLDOWN_FRAMES, 60, invulnerable frames after a hit (≥1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- frame_tick  in  1  one-cycle strobe per frame (start of vertical blank); positions stable while high
- restart  in  1  level; honoured only in OVER
- plane_y  in  10  plane top edge
- mountain1_x, mountain1_y  in  10 each  mountain 1 left edge / top edge
- mountain2_x, mountain2_y  in  10 each  mountain 2 left edge / top edge
- lava_x, lava_y  in  10 each  lava top-left corner
- life  out  10  remaining lives, zero-extended
- game_over  out  1  high in OVER
- hit  out  1  one-cycle pulse when a life is deducted
- invulnerable  out  1  high during COOLDOWN

Behaviour:
- Reset (rst sampled high on a clk edge): state=PLAYING, life=START_LIVES, game_over=0, hit=0, invulnerable=0, cooldown counter=0. rst overrides every other input, including mid-cooldown and in OVER.
- Overlap test: inclusive interval overlap on both axes.
  - All upper bounds (plane_y+PLANE_SIZE, mx+MOUNTAIN_W, lava_x+LAVA_SIZE, etc.) computed 11 bits wide; no 10-bit wrap. Positions near 1023 must not alias to 0.
  - Mountain y test is plane_y+PLANE_SIZE ≥ my.
  - coll = m1 | m2 | lava. Combinational from inputs; sampled only on frame_tick.
- FSM, advancing only on frame_tick unless noted:
  - PLAYING, coll=1:
    - If life==1: life←0, hit=1, go to OVER; game_over=1 on the same edge.
    - Else: life←life−1, hit=1, counter←COOLDOWN_FRAMES−1, go to COOLDOWN.
  - PLAYING, coll=0: stay.
  - COOLDOWN: coll ignored. If counter==0, go to PLAYING; else counter−1. invulnerable=1 throughout. With COOLDOWN_FRAMES=N, exactly N frame_ticks are immune.
  - OVER: frame_tick ignored; life holds 0. restart=1 on any clk edge (no frame_tick needed) loads life=START_LIVES, game_over=0, goes to PLAYING.
  - restart is ignored in PLAYING and COOLDOWN.
- Latency: outputs update on the clk edge where frame_tick=1; visible the next cycle. hit is high for exactly that one cycle.
- Multiple simultaneous overlaps (e.g. mountain and lava) cost one life only.
- restart and frame_tick on the same edge in OVER: restart wins, and the collision is not evaluated that frame.
- life never underflows below 0.

Optional Feature:
- Macro: COLLISION_HIT_COUNT_EN.
- Defined: adds output hit_count (8 bits), cleared by rst and by restart. Increments on each hit pulse and saturates at 255.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset → life=3, game_over=0. Plane_y=200, mountains at (300,400)/(500,400), lava at (700,0), tick → no change.
- Lava at (110,210), plane_y=200, tick → next cycle life=2, hit=1 for one cycle, invulnerable=1. Keep overlap, 60 ticks → life stays 2. 61st tick → life=1.
- Mountain1 at (90,216), plane_y=200 (bottom edge touches exactly), with lava overlapping the same frame → life decrements by exactly 1. Mountain1_y=217 → no hit.
- Three hits separated by cooldown → life 3→2→1→0 and game_over=1 on the third. Further ticks with overlap → life stays 0. restart=1 → life=3, game_over=0 next cycle.
- Wrap check: lava_x=1020, plane_y=1015, lava_y=1020 → no hit (x mismatch). mountain1_x=1010, mountain1_y=0, plane_y=1010 → no false hit from 10-bit wrap.
- rst asserted mid-COOLDOWN at counter=30 → life=3, invulnerable=0. The next overlapping tick deducts immediately. With COLLISION_HIT_COUNT_EN, hit_count reads 1 after that tick.
